// File: rtl/imm_encoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : imm_pkg                                                      |
// | Description : Shared types, constants and the single-cycle encode helper   |
// |               for the immediate encoder (inverse of the immediate          |
// |               extender).                                                   |
// | Contents    : imm_src_t (ImmSrc modes), state_t (FSM states), result_t,    |
// |               DATA_W/IMM_W/ROT_STEPS, eval_direct() for modes 00/01/10.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package imm_pkg;

  localparam int DATA_W    = 32;
  localparam int IMM_W     = 24;
  localparam int ROT_STEPS = 16;

  typedef enum logic [1:0] {
    IMM_ZX8  = 2'b00,
    IMM_ZX12 = 2'b01,
    IMM_BR24 = 2'b10,
    IMM_ROT  = 2'b11
  } imm_src_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic             fits;
    logic [IMM_W-1:0] imm;
    logic [3:0]       rot;
  } result_t;

  // Encodes the non-rotated modes. A non-encodable value returns all zeros,
  // so imm/rot are already forced to 0 whenever fits is 0.
  function automatic result_t eval_direct(input logic [DATA_W-1:0] v,
                                          input imm_src_t          src);
    result_t res;
    res = '{default: '0};
    case (src)
      IMM_ZX8: begin
        if (v[31:8] == 24'd0) begin
          res.fits = 1'b1;
          res.imm  = {16'd0, v[7:0]};
        end
      end
      IMM_ZX12: begin
        if (v[31:12] == 20'd0) begin
          res.fits = 1'b1;
          res.imm  = {12'd0, v[11:0]};
        end
      end
      IMM_BR24: begin
        // Word aligned, and bits 31:26 are pure sign extension of bit 25.
        if ((v[1:0] == 2'b00) && ((v[31:25] == 7'h00) || (v[31:25] == 7'h7F))) begin
          res.fits = 1'b1;
          res.imm  = v[25:2];
        end
      end
      default: res = '{default: '0};
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : imm_encoder_if                                               |
// | Description : Request/response bundle of the immediate encoder.            |
// | Signals     : in_valid/in_ready/value/imm_src  request side                |
// |               out_valid/out_ready/imm/rot/fits response side               |
// | Modports    : master (requester), slave (encoder)                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface imm_encoder_if;

  logic                        in_valid;
  logic                        in_ready;
  logic [imm_pkg::DATA_W-1:0]  value;
  imm_pkg::imm_src_t           imm_src;
  logic                        out_valid;
  logic                        out_ready;
  logic [imm_pkg::IMM_W-1:0]   imm;
  logic [3:0]                  rot;
  logic                        fits;

  modport master (
    output in_valid, value, imm_src, out_ready,
    input  in_ready, out_valid, imm, rot, fits
  );

  modport slave (
    input  in_valid, value, imm_src, out_ready,
    output in_ready, out_valid, imm, rot, fits
  );

endinterface
`default_nettype wire

// File: rtl/imm_encoder_rot_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rot_check                                                    |
// | Description : Combinational test of one rotation candidate. The value is   |
// |               encodable with rotation r when ROL(value, 2r) fits in 8 bits.|
// | Ports       : value [31:0] in  target value                                |
// |               r     [3:0]  in  rotation candidate                          |
// |               hit          out candidate encodes the value                 |
// |               imm8  [7:0]  out low byte of the rotated value               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rot_check
  import imm_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [3:0]        r,
  output logic              hit,
  output logic [7:0]        imm8
);

  logic [4:0]            shamt;
  logic [2*DATA_W-1:0]   dbl;
  logic [DATA_W-1:0]     rolled;

  // Rotate-left via a doubled word: the upper half after the shift is ROL.
  assign shamt  = {r, 1'b0};
  assign dbl    = {value, value} << shamt;
  assign rolled = dbl[2*DATA_W-1:DATA_W];
  assign hit    = (rolled[31:8] == 24'd0);
  assign imm8   = rolled[7:0];

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imm_encoder                                                  |
// | Description : Finds the 24-bit immediate field that the immediate extender |
// |               maps back to a 32-bit target, and reports whether it exists. |
// | Ports       : clk    in  rising-edge clock                                 |
// |               reset  in  synchronous active-high reset                     |
// |               bus    imm_encoder_if.slave request/response bundle          |
// | Config      : IMM_ENC_FAST_EN - rotated mode checks all 16 rotations in    |
// |               parallel (result at t+1); undefined uses one rotator and an  |
// |               iterative search (result at t+2+r, or t+17 on no hit).       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module imm_encoder
  import imm_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  imm_encoder_if.slave bus
);

  state_t            state;
  logic [DATA_W-1:0] value_q;
  logic [3:0]        cnt;
  logic              out_valid_q;
  logic              fits_q;
  logic [IMM_W-1:0]  imm_q;
  logic [3:0]        rot_q;
  result_t           direct_res;

  assign bus.in_ready  = (state == IDLE) & ~reset;
  assign bus.out_valid = out_valid_q;
  assign bus.imm       = imm_q;
  assign bus.rot       = rot_q;
  assign bus.fits      = fits_q;

  // Single-cycle modes are evaluated from the live request in the accept
  // cycle, so the registered result is visible at t+1.
  assign direct_res = eval_direct(bus.value, bus.imm_src);

`ifdef IMM_ENC_FAST_EN
  logic [ROT_STEPS-1:0] hit_vec;
  logic [7:0]           imm8_vec [ROT_STEPS];
  result_t              rot_res;
  result_t              accept_res;

  for (genvar g = 0; g < ROT_STEPS; g++) begin : g_rot
    rot_check u_rot_check (
      .value (bus.value),
      .r     (4'(g)),
      .hit   (hit_vec[g]),
      .imm8  (imm8_vec[g])
    );
  end

  // Descending scan so the lowest hitting rotation is the one that sticks.
  always_comb begin
    rot_res = '{default: '0};
    for (int i = ROT_STEPS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        rot_res.fits = 1'b1;
        rot_res.imm  = {16'd0, imm8_vec[i]};
        rot_res.rot  = 4'(i);
      end
    end
  end

  assign accept_res = (bus.imm_src == IMM_ROT) ? rot_res : direct_res;
`else
  logic       srch_hit;
  logic [7:0] srch_imm8;

  rot_check u_rot_check (
    .value (value_q),
    .r     (cnt),
    .hit   (srch_hit),
    .imm8  (srch_imm8)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      value_q     <= '0;
      cnt         <= 4'd0;
      out_valid_q <= 1'b0;
      fits_q      <= 1'b0;
      imm_q       <= '0;
      rot_q       <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            value_q <= bus.value;
            cnt     <= 4'd0;
`ifdef IMM_ENC_FAST_EN
            fits_q      <= accept_res.fits;
            imm_q       <= accept_res.imm;
            rot_q       <= accept_res.rot;
            out_valid_q <= 1'b1;
            state       <= DONE;
`else
            if (bus.imm_src == IMM_ROT) begin
              state <= SEARCH;
            end else begin
              fits_q      <= direct_res.fits;
              imm_q       <= direct_res.imm;
              rot_q       <= direct_res.rot;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
`endif
          end
        end
`ifndef IMM_ENC_FAST_EN
        SEARCH: begin
          if (srch_hit) begin
            fits_q      <= 1'b1;
            imm_q       <= {16'd0, srch_imm8};
            rot_q       <= cnt;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (cnt == 4'(ROT_STEPS - 1)) begin
            fits_q      <= 1'b0;
            imm_q       <= '0;
            rot_q       <= 4'd0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
